uart_tx_fifo_param: RTL and testbench

Parametrised UART transmitter with a buffered input FIFO. It is the successor to the fixed 8N1, 115200-baud, 1024-entry transmitter. Data width, FIFO depth, bit period, stop-bit count and inter-frame gap are all configurable. Parity mode is selectable at run time per frame, and transmission can be paused with an enable input. It sits between on-chip producers (CPU bus bridge, debug logger) and the board TX pin.

---
 rtl/uart_tx_fifo_param.sv | 195 +++++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter fed by a count-based FIFO.
// Frame: start, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits,
// GAP_BITS idle periods. Tx and TxBusy are registered and trail the FSM state by one clock.
module uart_tx_fifo_param #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_DIV   = 434,
  parameter int STOP_BITS  = 1,
  parameter int GAP_BITS   = 0
) (
  input  logic                         clock,
  input  logic                         nReset,
  input  logic                         TxFifoLoad,
  input  logic [DATA_BITS-1:0]         TxData,
  input  logic [1:0]                   ParityMode,
  input  logic                         TxEnable,
  output logic                         Tx,
  output logic                         TxBusy,
  output logic                         TxFifoEmpty,
  output logic                         TxFifoFull,
  output logic [$clog2(FIFO_DEPTH):0]  TxFifoCount
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 1024 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of two in 2..1024");
  end
  if (BAUD_DIV < 2 || BAUD_DIV > 65535) begin : g_bad_baud
    $error("uart_tx_fifo_param: BAUD_DIV must be 2..65535");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
  end
  if (GAP_BITS < 0 || GAP_BITS > 7) begin : g_bad_gap
    $error("uart_tx_fifo_param: GAP_BITS must be 0..7");
  end

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  DATA_LAST   = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST   = 4'(STOP_BITS - 1);
  localparam logic [3:0]  GAP_LAST    = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [DATA_BITS-1:0] head;
  logic                 push_ok, pop, can_start;

  state_t               state_q, state_d;
  logic [15:0]          baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           par_mode_q;
  logic                 par_bit_q, par_bit_d;
  logic                 bit_end, line;

  assign TxFifoEmpty = (count == '0);
  assign TxFifoFull  = (count == CW'(FIFO_DEPTH));
  assign TxFifoCount = count;
  assign head        = mem[rd_ptr];
  assign push_ok     = TxFifoLoad && !TxFifoFull;
  assign can_start   = !TxFifoEmpty && TxEnable;
  assign bit_end     = (baud_cnt == '0);

  // FIFO storage: written on every accepted push.
  // NOTE: the RAM has no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= TxData;
  end

  // FIFO pointers and occupancy count; pointers wrap naturally at the power-of-two depth.
  // NOTE: every state register uses non-blocking assignment so all flops update together.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Parity of the word being popped, chosen by the live ParityMode at the pop.
  always_comb begin
    case (ParityMode)
      2'b01:   par_bit_d = ^head;
      2'b10:   par_bit_d = ~^head;
      default: par_bit_d = 1'b1;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state, pop request and line value; a frame end with data waiting starts the next frame directly.
  // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    line    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (can_start) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        line = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        line = shift_q[0];
        if (bit_end && bit_cnt == DATA_LAST)
          state_d = (par_mode_q != 2'b00) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        line = par_bit_q;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end && bit_cnt == STOP_LAST) begin
          if (GAP_BITS > 0) state_d = S_GAP;
          else if (can_start) begin
            pop     = 1'b1;
            state_d = S_START;
          end else state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (bit_end && bit_cnt == GAP_LAST) begin
          if (can_start) begin
            pop     = 1'b1;
            state_d = S_START;
          end else state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Baud and bit counters plus shift register; a pop loads a fresh frame and restarts timing.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      par_mode_q <= 2'b00;
      par_bit_q  <= 1'b0;
    end else if (pop) begin
      shift_q    <= head;
      par_mode_q <= ParityMode;
      par_bit_q  <= par_bit_d;
      baud_cnt   <= BAUD_RELOAD;
      bit_cnt    <= '0;
    end else if (state_q != S_IDLE) begin
      if (bit_end) begin
        baud_cnt <= BAUD_RELOAD;
        bit_cnt  <= (state_d != state_q) ? 4'd0 : bit_cnt + 4'd1;
        if (state_q == S_DATA) shift_q <= shift_q >> 1;
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

  // Registered line and busy outputs; reset forces the line high immediately.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      Tx     <= 1'b1;
      TxBusy <= 1'b0;
    end else begin
      Tx     <= line;
      TxBusy <= (state_q != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Self-checking bench: table-driven frames, hand-written corner sequences and a
// randomized run compared against a frame-level reference model.
module tb_uart_tx_fifo_param;

  localparam int BAUD = 4;

  logic clock = 1'b0;
  logic nReset;

  // Instance A: 8 data bits, 4-deep FIFO, 1 stop, no gap.
  logic       load_a, en_a, tx_a, busy_a, empty_a, full_a;
  logic [7:0] data_a;
  logic [1:0] mode_a;
  logic [2:0] count_a;

  // Instance B: 9 data bits, 8-deep FIFO, 2 stop, 3 gap.
  logic       load_b, en_b, tx_b, busy_b, empty_b, full_b;
  logic [8:0] data_b;
  logic [1:0] mode_b;
  logic [3:0] count_b;

  int checks = 0;
  int failures = 0;

  uart_tx_fifo_param #(.DATA_BITS(8), .FIFO_DEPTH(4), .BAUD_DIV(BAUD), .STOP_BITS(1), .GAP_BITS(0)) dut_a (
    .clock(clock), .nReset(nReset), .TxFifoLoad(load_a), .TxData(data_a), .ParityMode(mode_a),
    .TxEnable(en_a), .Tx(tx_a), .TxBusy(busy_a), .TxFifoEmpty(empty_a), .TxFifoFull(full_a),
    .TxFifoCount(count_a));

  uart_tx_fifo_param #(.DATA_BITS(9), .FIFO_DEPTH(8), .BAUD_DIV(BAUD), .STOP_BITS(2), .GAP_BITS(3)) dut_b (
    .clock(clock), .nReset(nReset), .TxFifoLoad(load_b), .TxData(data_b), .ParityMode(mode_b),
    .TxEnable(en_b), .Tx(tx_b), .TxBusy(busy_b), .TxFifoEmpty(empty_b), .TxFifoFull(full_b),
    .TxFifoCount(count_b));

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  mode;
    int          nb;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic busy_of(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  // Frame built from the serial-format rules: start, LSB-first data, parity, stops, gap.
  function automatic void build_frame(input logic [8:0] d, input logic [1:0] m, input int db,
                                      input int sb, input int gb, output logic [15:0] f, output int nb);
    logic p;
    f  = '0;
    nb = 1;
    p  = 1'b0;
    for (int k = 0; k < db; k++) begin
      f[nb] = d[k];
      p     = p ^ d[k];
      nb    = nb + 1;
    end
    if (m != 2'b00) begin
      f[nb] = (m == 2'b01) ? p : (m == 2'b10) ? ~p : 1'b1;
      nb    = nb + 1;
    end
    for (int k = 0; k < sb + gb; k++) begin
      f[nb] = 1'b1;
      nb    = nb + 1;
    end
  endfunction

  // Samples nb bit periods starting at the current cycle; ok drops if a period is unstable or busy is low.
  task automatic capture(input bit sel, input int nb, output logic [15:0] bits, output bit ok);
    bits = '0;
    ok   = 1'b1;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < BAUD; c++) begin
        if (k != 0 || c != 0) step();
        if (c == 0) bits[k] = tx_of(sel);
        else if (tx_of(sel) !== bits[k]) ok = 1'b0;
        if (busy_of(sel) !== 1'b1) ok = 1'b0;
      end
    end
  endtask

  task automatic run_frame_a(input logic [7:0] d, input logic [1:0] m, input int nb,
                             input logic [15:0] exp, input string tag);
    logic [15:0] got;
    bit ok;
    mode_a = m;
    data_a = d;
    load_a = 1'b1;
    step();
    load_a = 1'b0;
    check({tag, "_empty_fall"}, empty_a, 1'b0);
    check({tag, "_tx_idle0"}, tx_a, 1'b1);
    step();
    check({tag, "_popped"}, count_a, 3'd0);
    check({tag, "_tx_idle1"}, tx_a, 1'b1);
    step();
    capture(1'b0, nb, got, ok);
    check({tag, "_bits"}, got, exp);
    check({tag, "_stable"}, ok, 1'b1);
    step();
    check({tag, "_busy_end"}, busy_a, 1'b0);
    check({tag, "_tx_end"}, tx_a, 1'b1);
  endtask

  task automatic random_b();
    logic [8:0]  q[$];
    logic [15:0] cur_f, prev_f;
    int t, next_ok, cur_s, prev_s, cur_len, prev_len, nb, i, max_cnt;
    bit pop_m, push_m;
    logic exp_tx, exp_busy;
    t = 0; next_ok = 0; cur_s = -1000; prev_s = -1000; cur_len = 0; prev_len = 0; max_cnt = 0;
    cur_f = '0; prev_f = '0;
    for (int n = 0; n < 1000; n++) begin
      load_b = ($urandom_range(0, 7) != 0);
      data_b = 9'($urandom);
      mode_b = 2'($urandom);
      en_b   = ($urandom_range(0, 15) != 0);
      t++;
      pop_m  = (q.size() > 0) && en_b && (t >= next_ok);
      push_m = load_b && (q.size() < 8);
      if (pop_m) begin
        prev_s = cur_s; prev_f = cur_f; prev_len = cur_len;
        build_frame(q.pop_front(), mode_b, 9, 2, 3, cur_f, nb);
        cur_len = nb * BAUD;
        cur_s   = t;
        next_ok = t + cur_len;
      end
      if (push_m) q.push_back(data_b);
      step();
      exp_tx = 1'b1;
      exp_busy = 1'b0;
      i = t - cur_s - 1;
      if (i >= 0 && i < cur_len) begin
        exp_tx = cur_f[i / BAUD];
        exp_busy = 1'b1;
      end else begin
        i = t - prev_s - 1;
        if (i >= 0 && i < prev_len) begin
          exp_tx = prev_f[i / BAUD];
          exp_busy = 1'b1;
        end
      end
      if (int'(count_b) > max_cnt) max_cnt = int'(count_b);
      check("rnd_tx", tx_b, exp_tx);
      check("rnd_busy", busy_b, exp_busy);
      check("rnd_count", count_b, q.size());
      check("rnd_full", full_b, q.size() == 8);
      check("rnd_empty", empty_b, q.size() == 0);
    end
    load_b = 1'b0;
    check("rnd_count_max", max_cnt <= 8, 1'b1);
  endtask

  initial begin
    logic [15:0] got;
    bit ok, idle_ok;

    vecs[0] = '{8'hA5, 2'b00, 10, {6'b0, 1'b1, 8'hA5, 1'b0}};
    vecs[1] = '{8'h07, 2'b01, 11, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}};
    vecs[2] = '{8'h07, 2'b10, 11, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}};
    vecs[3] = '{8'h07, 2'b11, 11, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}};
    vecs[4] = '{8'h3C, 2'b01, 11, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}};
    vecs[5] = '{8'hFF, 2'b10, 11, {5'b0, 1'b1, 1'b1, 8'hFF, 1'b0}};
    vecs[6] = '{8'h00, 2'b11, 11, {5'b0, 1'b1, 1'b1, 8'h00, 1'b0}};
    vecs[7] = '{8'h5A, 2'b00, 10, {6'b0, 1'b1, 8'h5A, 1'b0}};

    nReset = 1'b0;
    load_a = 1'b0; data_a = '0; mode_a = 2'b00; en_a = 1'b1;
    load_b = 1'b0; data_b = '0; mode_b = 2'b00; en_b = 1'b0;
    repeat (3) @(posedge clock);
    #1 nReset = 1'b1;

    // Reset state of both instances.
    check("rst_tx_a", tx_a, 1'b1);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_empty_a", empty_a, 1'b1);
    check("rst_full_a", full_a, 1'b0);
    check("rst_count_a", count_a, 3'd0);
    check("rst_tx_b", tx_b, 1'b1);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_empty_b", empty_b, 1'b1);
    check("rst_full_b", full_b, 1'b0);
    check("rst_count_b", count_b, 4'd0);

    // Single frames across data patterns and parity modes.
    for (int v = 0; v < 8; v++)
      run_frame_a(vecs[v].data, vecs[v].mode, vecs[v].nb, vecs[v].exp, $sformatf("vec%0d", v));

    // Fill a 4-deep FIFO with TxEnable low; the extra pushes are dropped.
    en_a = 1'b0;
    mode_a = 2'b00;
    for (int i = 1; i <= 6; i++) begin
      data_a = 8'(i);
      load_a = 1'b1;
      step();
      if (i == 3) begin
        check("fill3_count", count_a, 3'd3);
        check("fill3_full", full_a, 1'b0);
      end
      if (i == 4) begin
        check("fill4_count", count_a, 3'd4);
        check("fill4_full", full_a, 1'b1);
      end
    end
    load_a = 1'b0;
    check("drop_at_full_count", count_a, 3'd4);
    check("drop_at_full_full", full_a, 1'b1);
    en_a = 1'b1;
    step();
    step();
    for (int j = 1; j <= 4; j++) begin
      capture(1'b0, 10, got, ok);
      check($sformatf("b2b_bits%0d", j), got, {6'b0, 1'b1, 8'(j), 1'b0});
      check($sformatf("b2b_stable%0d", j), ok, 1'b1);
      if (j < 4) step();
    end
    step();
    check("b2b_busy_end", busy_a, 1'b0);
    idle_ok = 1'b1;
    repeat (40) begin
      step();
      if (tx_a !== 1'b1 || busy_a !== 1'b0) idle_ok = 1'b0;
    end
    check("b2b_no_extra_frames", idle_ok, 1'b1);
    check("b2b_drained", count_a, 3'd0);

    // Enable and parity changes mid-frame do not touch the frame in flight.
    en_a = 1'b0;
    mode_a = 2'b01;
    data_a = 8'h11; load_a = 1'b1; step();
    data_a = 8'h22; step();
    load_a = 1'b0;
    en_a = 1'b1;
    step();
    mode_a = 2'b00;
    en_a = 1'b0;
    step();
    capture(1'b0, 11, got, ok);
    check("midchg_bits", got, {5'b0, 1'b1, 1'b0, 8'h11, 1'b0});
    check("midchg_stable", ok, 1'b1);
    step();
    check("midchg_busy_end", busy_a, 1'b0);
    idle_ok = 1'b1;
    repeat (20) begin
      step();
      if (tx_a !== 1'b1) idle_ok = 1'b0;
    end
    check("hold_disabled_idle", idle_ok, 1'b1);
    check("hold_disabled_count", count_a, 3'd1);
    en_a = 1'b1;
    step();
    step();
    capture(1'b0, 10, got, ok);
    check("resume_bits", got, {6'b0, 1'b1, 8'h22, 1'b0});
    check("resume_stable", ok, 1'b1);
    step();
    check("resume_busy_end", busy_a, 1'b0);

    // Asynchronous reset in the middle of the data bits.
    mode_a = 2'b00;
    data_a = 8'h3C; load_a = 1'b1; step();
    data_a = 8'h55; step();
    data_a = 8'h66; step();
    load_a = 1'b0;
    check("mid_rst_start", tx_a, 1'b0);
    check("mid_rst_pre_count", count_a, 3'd2);
    repeat (10) step();
    nReset = 1'b0;
    #2;
    check("mid_rst_tx", tx_a, 1'b1);
    check("mid_rst_busy", busy_a, 1'b0);
    check("mid_rst_count", count_a, 3'd0);
    check("mid_rst_empty", empty_a, 1'b1);
    @(posedge clock);
    #1 nReset = 1'b1;
    idle_ok = 1'b1;
    repeat (40) begin
      step();
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || count_a !== 3'd0) idle_ok = 1'b0;
    end
    check("post_rst_idle", idle_ok, 1'b1);
    run_frame_a(8'h81, 2'b00, 10, {6'b0, 1'b1, 8'h81, 1'b0}, "post_rst");

    // Two stop bits and three gap periods between queued frames.
    mode_b = 2'b01;
    data_b = 9'h0A5; load_b = 1'b1; step();
    data_b = 9'h033; step();
    load_b = 1'b0;
    en_b = 1'b1;
    step();
    step();
    capture(1'b1, 16, got, ok);
    check("gap_bits0", got, {5'b11111, 1'b0, 9'h0A5, 1'b0});
    check("gap_stable0", ok, 1'b1);
    step();
    capture(1'b1, 16, got, ok);
    check("gap_bits1", got, {5'b11111, 1'b0, 9'h033, 1'b0});
    check("gap_stable1", ok, 1'b1);
    step();
    check("gap_busy_end", busy_b, 1'b0);
    check("gap_tx_end", tx_b, 1'b1);

    // Randomized push-while-draining run against the reference model.
    random_b();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
